// File: rtl/bar_plotter_if.sv
// Pixel-writer bus: the bar position from the animation stage and the pixel stream to the VGA adapter.
interface bar_plotter_if;
   logic [6:0] bar_y;
   logic [7:0] x_base;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot;
   logic       busy;

   modport master (
      output bar_y,
      output x_base,
      input  x_out,
      input  y_out,
      input  colour,
      input  plot,
      input  busy
   );

   modport slave (
      input  bar_y,
      input  x_base,
      output x_out,
      output y_out,
      output colour,
      output plot,
      output busy
   );
endinterface

// File: rtl/bar_plotter.sv
// Bar plotter: blanks the bar region after reset, then converts each bar height change into
// one pixel write per cycle, painting rows entering the bar and erasing rows leaving it.
module bar_plotter #(
   parameter int         BAR_WIDTH  = 16,
   parameter int         Y_TOP      = 21,
   parameter int         Y_BOT      = 80,
   parameter logic [2:0] COLOUR_ON  = 3'b010,
   parameter logic [2:0] COLOUR_OFF = 3'b000
) (
   input  logic          Clock,
   input  logic          reset,
   bar_plotter_if.slave  bus
);

   localparam logic [7:0] COL_LAST  = 8'(BAR_WIDTH - 1);
   localparam logic [6:0] ROW_TOP   = 7'(Y_TOP);
   localparam logic [6:0] ROW_BOT   = 7'(Y_BOT);
   localparam logic [6:0] ROW_EMPTY = 7'(Y_BOT + 1);

   typedef enum logic [1:0] {
      CLEAR_INIT,
      CLEAR,
      IDLE,
      DRAW
   } state_t;

   state_t     state;
   logic [6:0] row;
   logic [7:0] col;
   logic [6:0] span_last;
   logic [6:0] target;
   logic [6:0] last_y;
   logic [7:0] x_lat;

   logic [7:0] x_out_r;
   logic [6:0] y_out_r;
   logic [2:0] colour_r;
   logic       plot_r;
   logic       busy_r;

   logic [6:0] by;
   logic       rising;

   // Clamp the requested top row into the drawable range; an out-of-range request
   // below the region means an empty bar.
   always_comb begin
      by = bus.bar_y;
      if (bus.bar_y < ROW_TOP) begin
         by = ROW_TOP;
      end else if (bus.bar_y > ROW_EMPTY) begin
         by = ROW_EMPTY;
      end
      rising = (by < last_y);
   end

   always_ff @(posedge Clock) begin
      if (!reset) begin
         state     <= CLEAR_INIT;
         row       <= '0;
         col       <= '0;
         span_last <= '0;
         target    <= ROW_EMPTY;
         last_y    <= ROW_EMPTY;
         x_lat     <= '0;
         x_out_r   <= '0;
         y_out_r   <= '0;
         colour_r  <= '0;
         plot_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         unique case (state)
            CLEAR_INIT: begin
               row       <= ROW_TOP;
               col       <= '0;
               span_last <= ROW_BOT;
               target    <= ROW_EMPTY;
               x_lat     <= bus.x_base;
               x_out_r   <= bus.x_base;
               y_out_r   <= ROW_TOP;
               colour_r  <= COLOUR_OFF;
               plot_r    <= 1'b1;
               busy_r    <= 1'b1;
               state     <= CLEAR;
            end

            // The output registers always hold the pixel being written this cycle,
            // so the walk precomputes the next pixel one edge ahead.
            CLEAR, DRAW: begin
               if (col == COL_LAST) begin
                  if (row == span_last) begin
                     last_y <= target;
                     plot_r <= 1'b0;
                     busy_r <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     row     <= row + 7'd1;
                     col     <= '0;
                     x_out_r <= x_lat;
                     y_out_r <= row + 7'd1;
                  end
               end else begin
                  col     <= col + 8'd1;
                  x_out_r <= x_lat + col + 8'd1;
               end
            end

            IDLE: begin
               if (by != last_y) begin
                  row       <= rising ? by : last_y;
                  span_last <= rising ? (last_y - 7'd1) : (by - 7'd1);
                  col       <= '0;
                  target    <= by;
                  x_lat     <= bus.x_base;
                  x_out_r   <= bus.x_base;
                  y_out_r   <= rising ? by : last_y;
                  colour_r  <= rising ? COLOUR_ON : COLOUR_OFF;
                  plot_r    <= 1'b1;
                  busy_r    <= 1'b1;
                  state     <= DRAW;
               end
            end

            default: begin
               state <= CLEAR_INIT;
            end
         endcase
      end
   end

   assign bus.x_out  = x_out_r;
   assign bus.y_out  = y_out_r;
   assign bus.colour = colour_r;
   assign bus.plot   = plot_r;
   assign bus.busy   = busy_r;

endmodule

// File: tb/tb_bar_plotter.sv
// Scoreboard bench for bar_plotter: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_bar_plotter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic Clock;
   logic reset;
   bar_plotter_if bus ();

   pix_t expQ[$];
   int   checks;
   int   errors;
   int   plotsSeen;
   int   modelLast;

   bar_plotter dut (
      .Clock (Clock),
      .reset (reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Monitor: every plotted pixel must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      pix_t got;
      pix_t want;
      if (bus.plot) begin
         got = '{x: bus.x_out, y: bus.y_out, c: bus.colour};
         checks++;
         plotsSeen++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_plot got x=%0d y=%0d c=%0d, required no plot", got.x, got.y, got.c);
         end else begin
            want = expQ.pop_front();
            if (got != want) begin
               errors++;
               $display("[TB] FAIL pixel got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                        got.x, got.y, got.c, want.x, want.y, want.c);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic pushRows(input int first, input int last, input logic [7:0] xb, input logic [2:0] c);
      for (int r = first; r <= last; r++) begin
         for (int k = 0; k < 16; k++) begin
            pix_t p;
            p.x = xb + 8'(k);
            p.y = 7'(r);
            p.c = c;
            expQ.push_back(p);
         end
      end
   endtask

   task automatic pushSpan(input int barY, input logic [7:0] xb);
      int b;
      b = (barY < 21) ? 21 : ((barY > 81) ? 81 : barY);
      if (b < modelLast) pushRows(b, modelLast - 1, xb, 3'b010);
      else if (b > modelLast) pushRows(modelLast, b - 1, xb, 3'b000);
      modelLast = b;
   endtask

   task automatic applyStimulus(input int barY, input logic [7:0] xb);
      @(posedge Clock);
      #1;
      bus.bar_y  = 7'(barY);
      bus.x_base = xb;
      pushSpan(barY, xb);
   endtask

   task automatic countPlots(output int n);
      n = 0;
      @(negedge Clock);
      while (bus.plot && n < 5000) begin
         n++;
         @(negedge Clock);
      end
   endtask

   task automatic waitDone(input string name, input int expPlots);
      int n;
      @(negedge Clock);
      checkOutput({name, "_idle_cycle_plot"}, int'(bus.plot), 0);
      countPlots(n);
      checkOutput({name, "_plot_count"}, n, expPlots);
      checkOutput({name, "_busy_after"}, int'(bus.busy), 0);
      checkOutput({name, "_queue_left"}, expQ.size(), 0);
   endtask

   task automatic releaseAndClear(input string name);
      int n;
      @(posedge Clock);
      #1;
      reset = 1'b1;
      modelLast = 81;
      pushRows(21, 80, 8'd0, 3'b000);
      @(negedge Clock);
      checkOutput({name, "_init_plot"}, int'(bus.plot), 0);
      countPlots(n);
      checkOutput({name, "_plot_count"}, n, 960);
      checkOutput({name, "_busy_after"}, int'(bus.busy), 0);
      checkOutput({name, "_queue_left"}, expQ.size(), 0);
   endtask

   task automatic quietCheck(input string name, input int cycles);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clock);
         if (bus.plot || bus.busy) n++;
      end
      checkOutput(name, n, 0);
   endtask

   initial begin
      int n;
      int base;
      checks     = 0;
      errors     = 0;
      plotsSeen  = 0;
      modelLast  = 81;
      reset      = 1'b0;
      bus.bar_y  = 7'd81;
      bus.x_base = 8'd0;

      // Reset state and the power-on clear
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      checkOutput("reset_x_out", int'(bus.x_out), 0);
      checkOutput("reset_y_out", int'(bus.y_out), 0);
      checkOutput("reset_colour", int'(bus.colour), 0);
      checkOutput("reset_plot", int'(bus.plot), 0);
      checkOutput("reset_busy", int'(bus.busy), 0);
      releaseAndClear("clear1");
      quietCheck("idle_quiet_81", 10);

      // Rise by one row, fall by one row, then a fall with an offset origin
      applyStimulus(80, 8'd0);
      waitDone("rise1", 16);
      applyStimulus(81, 8'd0);
      waitDone("fall1", 16);
      applyStimulus(75, 8'd150);
      waitDone("rise6_x150", 96);
      applyStimulus(81, 8'd0);
      waitDone("fall6", 96);

      // Bar change arriving mid-span is picked up after a single idle cycle
      applyStimulus(71, 8'd0);
      @(negedge Clock);
      checkOutput("chg_idle_cycle_plot", int'(bus.plot), 0);
      n = 0;
      @(negedge Clock);
      while (bus.plot && n < 5000) begin
         n++;
         if (n == 50) begin
            bus.bar_y = 7'd69;
            pushSpan(69, 8'd0);
         end
         @(negedge Clock);
      end
      checkOutput("chg_span1_count", n, 160);
      checkOutput("chg_gap_busy", int'(bus.busy), 0);
      countPlots(n);
      checkOutput("chg_span2_count", n, 32);
      checkOutput("chg_queue_left", expQ.size(), 0);

      // Clamping at both ends
      applyStimulus(81, 8'd0);
      waitDone("empty69", 192);
      applyStimulus(5, 8'd0);
      waitDone("clamp_top", 960);
      applyStimulus(127, 8'd0);
      waitDone("clamp_bot", 960);
      quietCheck("quiet_127", 8);
      applyStimulus(81, 8'd0);
      quietCheck("quiet_last81", 8);

      // Reset in the middle of a span aborts it and restarts the clear
      applyStimulus(71, 8'd0);
      base = plotsSeen;
      n = 0;
      while ((plotsSeen - base) < 20 && n < 1000) begin
         @(posedge Clock);
         #1;
         n++;
      end
      checkOutput("mid_reset_reached", int'((plotsSeen - base) >= 20), 1);
      reset     = 1'b0;
      bus.bar_y = 7'd81;
      @(posedge Clock);
      #1;
      expQ.delete();
      @(negedge Clock);
      checkOutput("mid_reset_plot", int'(bus.plot), 0);
      checkOutput("mid_reset_busy", int'(bus.busy), 0);
      releaseAndClear("clear2");
      quietCheck("quiet_after_clear2", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout got running, required finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
